// File: rtl/execute_stage_pipe.sv
// Integer execute stage: ALU, icc register, Bicc/CALL resolution, multi-cycle
// multiply. One instruction in flight, one output register toward memory.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | ready for a new instruction once the output register is free
// ST_MUL  | multiply in progress; cnt_q counts down to the load cycle
module execute_stage_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 64,
    parameter int DISP_WIDTH = 30,
    parameter int MUL_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PC_WIDTH-1:0]   in_pc,
    input  logic [3:0]            in_op,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  in_set_cc,
    input  logic [3:0]            in_cond,
    input  logic                  in_annul,
    input  logic [DISP_WIDTH-1:0] in_disp,
    input  logic [4:0]            in_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [DATA_WIDTH-1:0] out_result_hi,
    output logic [4:0]            out_rd,
    output logic                  out_taken,
    output logic [PC_WIDTH-1:0]   out_target,
    output logic                  out_annul,
    output logic [3:0]            out_icc
);
    localparam int SH_W  = $clog2(DATA_WIDTH);
    localparam int CNT_W = $clog2(MUL_CYCLES + 1);
    localparam int MSB   = DATA_WIDTH - 1;

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4,  OP_ANDN = 4'd5,  OP_ORN  = 4'd6,  OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8,  OP_SRA  = 4'd9,  OP_PASS = 4'd10, OP_UMUL = 4'd11;
    localparam logic [3:0] OP_SMUL = 4'd12, OP_BICC = 4'd13, OP_CALL = 4'd14;

    typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d, result_hi_q, result_hi_d;
    logic [4:0]              rd_q, rd_d, mul_rd_q, mul_rd_d;
    logic                    taken_q, taken_d, annul_q, annul_d;
    logic [PC_WIDTH-1:0]     target_q, target_d;
    logic [3:0]              icc_q, icc_d;
    logic [DATA_WIDTH-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic                    mul_signed_q, mul_signed_d, mul_set_cc_q, mul_set_cc_d;

    logic [DATA_WIDTH:0]     add_full;
    logic [DATA_WIDTH-1:0]   sub_diff, alu_res;
    logic [SH_W-1:0]         sh_amt;
    logic [PC_WIDTH-1:0]     disp_ext, br_target, ctl_target;
    logic                    alu_v, alu_c, cond_base, cond_true, ctl_taken, ctl_annul;
    logic [3:0]              alu_icc, mul_icc;
    logic                    xfer, is_mul, cc_en;
    logic [2*DATA_WIDTH-1:0] mul_ext_a, mul_ext_b, mul_prod;

    assign add_full  = {1'b0, in_a} + {1'b0, in_b};
    assign sub_diff  = in_a - in_b;
    assign sh_amt    = in_b[SH_W-1:0];
    assign disp_ext  = PC_WIDTH'($signed(in_disp));
    assign br_target = in_pc + (disp_ext << 2);
    assign is_mul    = (in_op == OP_UMUL) || (in_op == OP_SMUL);
    // Only ALU and multiply ops (codes 0..12) may write icc.
    assign cc_en     = in_set_cc && (in_op <= OP_SMUL);

    assign in_ready = !reset && (state_q == ST_IDLE) && !flush && (!out_valid_q || out_ready);
    assign xfer     = in_valid && in_ready;

    // The multiplier works from operands captured at acceptance; the product
    // is only consumed on the final counter cycle.
    assign mul_ext_a = mul_signed_q ? {{DATA_WIDTH{mul_a_q[MSB]}}, mul_a_q} : {{DATA_WIDTH{1'b0}}, mul_a_q};
    assign mul_ext_b = mul_signed_q ? {{DATA_WIDTH{mul_b_q[MSB]}}, mul_b_q} : {{DATA_WIDTH{1'b0}}, mul_b_q};
    assign mul_prod  = mul_ext_a * mul_ext_b;
    assign mul_icc   = {mul_prod[MSB], mul_prod[MSB:0] == '0, 2'b00};

    // Single-cycle ALU, condition evaluation against the current icc, and control transfer.
    always_comb begin
        alu_res    = '0;
        alu_v      = 1'b0;
        alu_c      = 1'b0;
        ctl_taken  = 1'b0;
        ctl_target = '0;
        ctl_annul  = 1'b0;
        case (in_cond[2:0])
            3'd0:    cond_base = 1'b0;
            3'd1:    cond_base = icc_q[2];
            3'd2:    cond_base = icc_q[2] | (icc_q[3] ^ icc_q[1]);
            3'd3:    cond_base = icc_q[3] ^ icc_q[1];
            3'd4:    cond_base = icc_q[0] | icc_q[2];
            3'd5:    cond_base = icc_q[0];
            3'd6:    cond_base = icc_q[3];
            default: cond_base = icc_q[1];
        endcase
        cond_true = cond_base ^ in_cond[3];
        case (in_op)
            OP_ADD: begin
                alu_res = add_full[MSB:0];
                alu_c   = add_full[DATA_WIDTH];
                alu_v   = (in_a[MSB] == in_b[MSB]) && (add_full[MSB] != in_a[MSB]);
            end
            OP_SUB: begin
                alu_res = sub_diff;
                alu_c   = in_a < in_b;
                alu_v   = (in_a[MSB] != in_b[MSB]) && (sub_diff[MSB] != in_a[MSB]);
            end
            OP_AND:  alu_res = in_a & in_b;
            OP_OR:   alu_res = in_a | in_b;
            OP_XOR:  alu_res = in_a ^ in_b;
            OP_ANDN: alu_res = in_a & ~in_b;
            OP_ORN:  alu_res = in_a | ~in_b;
            OP_SLL:  alu_res = in_a << sh_amt;
            OP_SRL:  alu_res = in_a >> sh_amt;
            OP_SRA:  alu_res = $unsigned($signed(in_a) >>> sh_amt);
            OP_PASS: alu_res = in_b;
            OP_BICC: begin
                ctl_taken  = cond_true;
                ctl_target = br_target;
                ctl_annul  = in_annul && (!cond_true || (in_cond == 4'd8));
            end
            OP_CALL: begin
                ctl_taken  = 1'b1;
                ctl_target = br_target;
                alu_res    = DATA_WIDTH'(in_pc);
            end
            default: alu_res = '0;
        endcase
        alu_icc = {alu_res[MSB], alu_res == '0, alu_v, alu_c};
    end

    // Next-state: handshake on the output register, multiply countdown, flush override.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        result_d     = result_q;
        result_hi_d  = result_hi_q;
        rd_d         = rd_q;
        taken_d      = taken_q;
        target_d     = target_q;
        annul_d      = annul_q;
        icc_d        = icc_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        mul_signed_d = mul_signed_q;
        mul_set_cc_d = mul_set_cc_q;
        mul_rd_d     = mul_rd_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (xfer && is_mul) begin
                    state_d      = ST_MUL;
                    cnt_d        = CNT_W'(MUL_CYCLES - 1);
                    mul_a_d      = in_a;
                    mul_b_d      = in_b;
                    mul_signed_d = (in_op == OP_SMUL);
                    mul_set_cc_d = in_set_cc;
                    mul_rd_d     = in_rd;
                end else if (xfer) begin
                    out_valid_d = 1'b1;
                    result_d    = alu_res;
                    result_hi_d = '0;
                    rd_d        = in_rd;
                    taken_d     = ctl_taken;
                    target_d    = ctl_target;
                    annul_d     = ctl_annul;
                    if (cc_en) begin
                        icc_d = alu_icc;
                    end
                end
            end
            ST_MUL: begin
                cnt_d = cnt_q - CNT_W'(1);
                if ((cnt_q == CNT_W'(1)) && !flush) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    result_d    = mul_prod[MSB:0];
                    result_hi_d = mul_prod[2*DATA_WIDTH-1:DATA_WIDTH];
                    rd_d        = mul_rd_q;
                    taken_d     = 1'b0;
                    target_d    = '0;
                    annul_d     = 1'b0;
                    if (mul_set_cc_q) begin
                        icc_d = mul_icc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A flushed multiply never reaches the output register nor icc.
        if (flush) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            result_q     <= '0;
            result_hi_q  <= '0;
            rd_q         <= '0;
            taken_q      <= 1'b0;
            target_q     <= '0;
            annul_q      <= 1'b0;
            icc_q        <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_signed_q <= 1'b0;
            mul_set_cc_q <= 1'b0;
            mul_rd_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            result_q     <= result_d;
            result_hi_q  <= result_hi_d;
            rd_q         <= rd_d;
            taken_q      <= taken_d;
            target_q     <= target_d;
            annul_q      <= annul_d;
            icc_q        <= icc_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            mul_signed_q <= mul_signed_d;
            mul_set_cc_q <= mul_set_cc_d;
            mul_rd_q     <= mul_rd_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_result    = result_q;
    assign out_result_hi = result_hi_q;
    assign out_rd        = rd_q;
    assign out_taken     = taken_q;
    assign out_target    = target_q;
    assign out_annul     = annul_q;
    assign out_icc       = icc_q;
endmodule

// File: tb/tb_execute_stage_pipe.sv
// Bench for execute_stage_pipe: directed scenarios plus a randomized run
// scored against an arithmetic reference model.
module tb_execute_stage_pipe;
    localparam int M = 4;

    logic        clk, reset, flush, in_valid, in_ready, in_set_cc, in_annul;
    logic [63:0] in_pc;
    logic [3:0]  in_op, in_cond;
    logic [31:0] in_a, in_b;
    logic [29:0] in_disp;
    logic [4:0]  in_rd;
    logic        out_valid, out_ready, out_taken, out_annul;
    logic [31:0] out_result, out_result_hi;
    logic [4:0]  out_rd;
    logic [63:0] out_target;
    logic [3:0]  out_icc;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] hi;
        logic        taken;
        logic [63:0] target;
        logic        annul;
        logic [4:0]  rd;
        logic [3:0]  icc;
    } exp_t;

    exp_t got;
    assign got = {out_result, out_result_hi, out_taken, out_target, out_annul, out_rd, out_icc};

    int tests_run = 0;
    int tests_failed = 0;
    logic [3:0] m_icc = 4'h0;

    execute_stage_pipe #(.DATA_WIDTH(32), .PC_WIDTH(64), .DISP_WIDTH(30), .MUL_CYCLES(M)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_set_cc(in_set_cc),
        .in_cond(in_cond), .in_annul(in_annul), .in_disp(in_disp), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_result_hi(out_result_hi), .out_rd(out_rd), .out_taken(out_taken),
        .out_target(out_target), .out_annul(out_annul), .out_icc(out_icc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: 64-bit arithmetic on the operands, flags from range checks.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [63:0] pc, input logic [3:0] cond, input logic annul,
                                   input logic [29:0] disp, input logic [4:0] rd, input logic set_cc,
                                   input logic [3:0] icc);
        exp_t e;
        longint sa, sb, sr;
        longint unsigned ur;
        logic n, z, v, c, t, cc_ok;
        int sh;
        e = '0;
        e.rd = rd;
        e.icc = icc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b[4:0]);
        v = 1'b0;
        c = 1'b0;
        t = 1'b0;
        cc_ok = set_cc;
        {n, z} = {icc[3], icc[2]};
        case (op)
            4'd0: begin
                ur = longint'(a) + longint'(b);
                e.result = ur[31:0];
                c = (ur > 64'hFFFF_FFFF);
                sr = sa + sb;
                v = (sr != longint'($signed(sr[31:0])));
            end
            4'd1: begin
                e.result = a - b;
                c = (a < b);
                sr = sa - sb;
                v = (sr != longint'($signed(sr[31:0])));
            end
            4'd2: e.result = a & b;
            4'd3: e.result = a | b;
            4'd4: e.result = a ^ b;
            4'd5: e.result = a & ~b;
            4'd6: e.result = a | ~b;
            4'd7: e.result = a << sh;
            4'd8: e.result = a >> sh;
            4'd9: e.result = $unsigned($signed(a) >>> sh);
            4'd10: e.result = b;
            4'd11: begin
                ur = longint'(a) * longint'(b);
                {e.hi, e.result} = ur;
            end
            4'd12: begin
                sr = sa * sb;
                {e.hi, e.result} = sr;
            end
            4'd13: begin
                case (cond[2:0])
                    3'd0: t = 1'b0;
                    3'd1: t = z;
                    3'd2: t = z || (n != icc[1]);
                    3'd3: t = (n != icc[1]);
                    3'd4: t = icc[0] || z;
                    3'd5: t = icc[0];
                    3'd6: t = n;
                    default: t = icc[1];
                endcase
                if (cond[3]) t = !t;
                e.taken = t;
                e.target = pc + 64'(longint'($signed(disp)) * 4);
                e.annul = annul && (!t || cond == 4'd8);
                cc_ok = 1'b0;
            end
            4'd14: begin
                e.taken = 1'b1;
                e.target = pc + 64'(longint'($signed(disp)) * 4);
                e.result = pc[31:0];
                cc_ok = 1'b0;
            end
            default: cc_ok = 1'b0;
        endcase
        if (cc_ok) e.icc = {e.result[31], e.result == 32'h0, v, c};
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Presents one instruction at a negedge, returns at the negedge after acceptance.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] pc, input logic [3:0] cond, input logic annul,
                        input logic [29:0] disp, input logic set_cc, output exp_t e);
        int waited;
        waited = 0;
        in_op = op; in_a = a; in_b = b; in_pc = pc; in_cond = cond; in_annul = annul;
        in_disp = disp; in_set_cc = set_cc; in_rd = 5'($urandom); in_valid = 1'b1;
        #1;
        while (!in_ready && waited < 20) begin
            @(negedge clk); #1; waited++;
        end
        if (!in_ready) begin
            tests_run++; tests_failed++;
            $display("FAIL send_timeout: in_ready=%b required 1 within 20 cycles", in_ready);
            in_valid = 1'b0; e = '0;
            return;
        end
        e = model(op, a, b, pc, cond, annul, disp, in_rd, set_cc, m_icc);
        m_icc = e.icc;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        in_op = 4'd0; in_a = 32'h1; in_b = 32'h2; in_pc = '0; in_cond = '0; in_annul = 1'b0;
        in_disp = '0; in_rd = 5'd3; in_set_cc = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        reset = 1'b0; in_valid = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || got !== exp_t'(0)) begin
            tests_failed++; $display("FAIL reset_outputs: valid=%b data=%h required 0", out_valid, got);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_ready: got %b required 1", in_ready); end
        m_icc = 4'h0;
    endtask

    task automatic test_add_overflow();
        exp_t e;
        send(4'd0, 32'h7FFF_FFFF, 32'h1, 64'h0, 4'd0, 1'b0, 30'd0, 1'b1, e);
        tests_run++;
        if (out_valid !== 1'b1 || out_result !== 32'h8000_0000 || out_icc !== 4'b1010) begin
            tests_failed++;
            $display("FAIL add_overflow: valid=%b result=%h icc=%b required 1 80000000 1010", out_valid, out_result, out_icc);
        end
        tests_run++;
        if (got !== e) begin tests_failed++; $display("FAIL add_model: got %h required %h", got, e); end
        idle(2);
    endtask

    task automatic test_back_to_back();
        exp_t e1, e2;
        send(4'd1, 32'd5, 32'd5, 64'h0, 4'd0, 1'b0, 30'd0, 1'b1, e1);
        tests_run++;
        if (out_valid !== 1'b1 || out_icc !== 4'b0100) begin
            tests_failed++; $display("FAIL sub_icc: valid=%b icc=%b required 1 0100", out_valid, out_icc);
        end
        send(4'd13, 32'h0, 32'h0, 64'h1000, 4'd1, 1'b0, 30'h3FFF_FFFC, 1'b0, e2);
        tests_run++;
        if (out_valid !== 1'b1 || out_taken !== 1'b1 || out_target !== 64'hFF0 || out_annul !== 1'b0) begin
            tests_failed++;
            $display("FAIL be_taken: valid=%b taken=%b target=%h annul=%b required 1 1 ff0 0", out_valid, out_taken, out_target, out_annul);
        end
        tests_run++;
        if (got !== e2) begin tests_failed++; $display("FAIL be_model: got %h required %h", got, e2); end
        idle(2);
    endtask

    task automatic test_bicc_annul();
        exp_t e;
        send(4'd13, 32'h0, 32'h0, 64'h2000, 4'd9, 1'b1, 30'd8, 1'b0, e);
        tests_run++;
        if (out_taken !== 1'b0 || out_annul !== 1'b1) begin
            tests_failed++; $display("FAIL bne_annul: taken=%b annul=%b required 0 1", out_taken, out_annul);
        end
        send(4'd13, 32'h0, 32'h0, 64'h2000, 4'd8, 1'b1, 30'd8, 1'b0, e);
        tests_run++;
        if (out_taken !== 1'b1 || out_annul !== 1'b1 || out_target !== 64'h2020) begin
            tests_failed++; $display("FAIL ba_annul: taken=%b annul=%b target=%h required 1 1 2020", out_taken, out_annul, out_target);
        end
        send(4'd14, 32'h0, 32'h0, 64'hABCD_0000_1234_5678, 4'd0, 1'b1, 30'd4, 1'b0, e);
        tests_run++;
        if (got !== e || out_result !== 32'h1234_5678 || out_annul !== 1'b0) begin
            tests_failed++; $display("FAIL call: got %h required %h", got, e);
        end
        idle(2);
    endtask

    task automatic test_smul();
        exp_t e;
        int bad;
        bad = 0;
        send(4'd12, 32'hFFFF_FFFD, 32'd7, 64'h0, 4'd0, 1'b0, 30'd0, 1'b1, e);
        for (int k = 1; k < M; k++) begin
            #1;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL smul_busy: %0d busy cycles wrong, required 0", bad); end
        tests_run++;
        if (out_valid !== 1'b1 || out_result !== 32'hFFFF_FFEB || out_result_hi !== 32'hFFFF_FFFF || got !== e) begin
            tests_failed++; $display("FAIL smul_result: valid=%b got %h required %h", out_valid, got, e);
        end
        idle(2);
    endtask

    task automatic test_backpressure();
        exp_t e1, e2;
        int bad;
        bad = 0;
        out_ready = 1'b0;
        send(4'd0, 32'h1234, 32'h1, 64'h0, 4'd0, 1'b0, 30'd0, 1'b1, e1);
        in_op = 4'd1; in_a = 32'h1; in_b = 32'h2; in_set_cc = 1'b1; in_rd = 5'd9; in_valid = 1'b1;
        repeat (3) begin
            #1;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || got !== e1) bad++;
            @(negedge clk);
        end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL hold: %0d held cycles wrong, required 0 (last %h vs %h)", bad, got, e1); end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL release_ready: got %b required 1", in_ready); end
        e2 = model(in_op, in_a, in_b, in_pc, in_cond, in_annul, in_disp, in_rd, in_set_cc, m_icc);
        m_icc = e2.icc;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || got !== e2) begin
            tests_failed++; $display("FAIL second_result: valid=%b got %h required %h", out_valid, got, e2);
        end
        idle(2);
    endtask

    task automatic test_flush();
        exp_t e;
        logic [3:0] icc_keep;
        int bad;
        // flush in the second multiply cycle
        icc_keep = m_icc;
        send(4'd11, 32'hFFFF_FFFF, 32'h2, 64'h0, 4'd0, 1'b0, 30'd0, 1'b1, e);
        m_icc = icc_keep;
        @(negedge clk);
        flush = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_blocks: in_ready=%b required 0", in_ready); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL flush_mul: valid=%b ready=%b required 0 1", out_valid, in_ready);
        end
        bad = 0;
        repeat (M + 1) begin @(negedge clk); if (out_valid !== 1'b0) bad++; end
        tests_run++;
        if (bad != 0 || out_icc !== m_icc) begin
            tests_failed++; $display("FAIL flush_mul_quiet: rises=%0d icc=%b required 0 %b", bad, out_icc, m_icc);
        end
        // flush a held result
        out_ready = 1'b0;
        send(4'd2, 32'h0, 32'hFF, 64'h0, 4'd0, 1'b0, 30'd0, 1'b1, e);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_icc !== m_icc) begin
            tests_failed++; $display("FAIL flush_held: valid=%b ready=%b icc=%b required 0 1 %b", out_valid, in_ready, out_icc, m_icc);
        end
        out_ready = 1'b1;
        // flush in the completion cycle discards the product and its flags
        icc_keep = m_icc;
        send(4'd12, 32'h8000_0000, 32'h8000_0000, 64'h0, 4'd0, 1'b0, 30'd0, 1'b1, e);
        m_icc = icc_keep;
        repeat (M - 2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bad = 0;
        repeat (3) begin #1; if (out_valid !== 1'b0) bad++; @(negedge clk); end
        tests_run++;
        if (bad != 0 || out_icc !== m_icc) begin
            tests_failed++; $display("FAIL flush_complete: rises=%0d icc=%b required 0 %b", bad, out_icc, m_icc);
        end
        // reset mid-multiply
        send(4'd11, 32'h5, 32'h5, 64'h0, 4'd0, 1'b0, 30'd0, 1'b1, e);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_icc = 4'h0;
        bad = 0;
        repeat (M + 1) begin #1; if (out_valid !== 1'b0) bad++; @(negedge clk); end
        tests_run++;
        if (bad != 0 || out_icc !== 4'h0 || in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_mid_mul: rises=%0d icc=%b ready=%b required 0 0000 1", bad, out_icc, in_ready);
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        int issued, cyc;
        issued = 0; cyc = 0;
        while ((issued < 300 || q.size() != 0) && cyc < 4000) begin
            out_ready = (issued >= 300) || ($urandom_range(0, 3) != 0);
            in_valid = (issued < 300) && ($urandom_range(0, 3) != 0);
            in_op = 4'($urandom); in_a = pick(); in_b = pick(); in_pc = {$urandom, $urandom};
            in_cond = 4'($urandom); in_annul = 1'($urandom); in_disp = 30'($urandom);
            in_rd = 5'($urandom); in_set_cc = 1'($urandom);
            #1;
            if (out_valid && out_ready) begin
                tests_run++;
                if (q.size() == 0) begin
                    tests_failed++; $display("FAIL rand_spurious: out_valid=1 with no result expected");
                end else begin
                    e = q.pop_front();
                    if (got !== e) begin tests_failed++; $display("FAIL rand_result: got %h required %h", got, e); end
                end
            end
            if (in_valid && in_ready) begin
                e = model(in_op, in_a, in_b, in_pc, in_cond, in_annul, in_disp, in_rd, in_set_cc, m_icc);
                m_icc = e.icc;
                q.push_back(e);
                issued++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tests_run++;
        if (q.size() != 0 || issued < 300) begin
            tests_failed++; $display("FAIL rand_drain: issued=%0d pending=%0d required 300 0", issued, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_back_to_back();
        test_bicc_annul();
        test_smul();
        test_backpressure();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
